logging_capture_writer: RTL
===========================

Name: logging_capture_writer

Overview:
- Upstream producer for the logging blockram, the 2048 x 16 data log that the sbus memory window reads back.
- Accepts a 16-bit sample stream and buffers it in a small FIFO.
- Writes each sample into the blockram through a Wishbone master write port at an auto-incrementing pointer.
- Exposes control/status and the current write pointer to the sbus through a 2-register Wishbone slave.

Parameters:
- ADR_W, 12: blockram address width, matching the memory window's 12-bit address.
- MEM_WORDS, 2048: number of log words; the last valid address is MEM_WORDS-1.
- FIFO_DEPTH_LOG2, 2: sample FIFO depth is 2**FIFO_DEPTH_LOG2 (4 words).

Ports:
- wb_clk_i  in  1  master clock
- wb_rst_i  in  1  asynchronous reset, active-high
- sample_dat_i  in  16  sample data
- sample_vld_i  in  1  single-cycle strobe; sample_dat_i is valid in that cycle
- sbus_wb_cyc_i, sbus_wb_stb_i, sbus_wb_we_i  in  1 each  sbus slave control
- sbus_wb_adr_i  in  16  register select; only bit 1 is decoded
- sbus_wb_sel_i  in  2  byte selects; ignored, full 16-bit access
- sbus_wb_dat_i  in  16  sbus write data
- sbus_wb_dat_o  out  16  sbus read data
- sbus_wb_ack_o  out  1  sbus ack
- lbram_wb_cyc_o, lbram_wb_stb_o, lbram_wb_we_o  out  1 each  blockram master control
- lbram_wb_adr_o  out  ADR_W  blockram write address
- lbram_wb_dat_o  out  16  blockram write data
- lbram_wb_ack_i  in  1  blockram ack
- log_full_o  out  1  log-full flag, usable as an interrupt

Behaviour:
- Reset (async): all outputs 0.
  - ptr=0; enable=0; wrap=0; full=0; overflow=0; FIFO empty; FSM=IDLE; clear_pend=0.
- Register map:
  - 0x0 CTRL/STAT (RW): bit0 enable, bit1 wrap; bit2 clear (write-1, self-clearing, reads 0).
  - 0x0 status bits (RO): bit8 full, bit9 overflow (sticky), bit10 busy (FSM!=IDLE or FIFO non-empty). Other bits read 0.
  - 0x2 PTR (RO): {0, ptr}. Writes to 0x2 are ignored.
- sbus ack: combinational, sbus_wb_ack_o = cyc && stb, zero wait states. Register writes take effect on the clock edge of the acked cycle.
- Sample acceptance:
  - A sample is accepted when sample_vld_i && enable && !full && !clear_pend.
  - If the FIFO is full at acceptance, the sample is dropped and overflow<=1.
  - A sample arriving while not enabled, or while full, is dropped silently (overflow unchanged).
  - On the FIFO, push and pop in the same cycle are both legal; count is unchanged.
- FSM IDLE:
  - If clear_pend: ptr<=0, full<=0, overflow<=0, FIFO flushed, clear_pend<=0; stay IDLE.
  - Else if FIFO non-empty and !full: pop the head into the data register and go to WRITE. cyc/stb/we rise on the next edge.
- FSM WRITE:
  - cyc=stb=we=1; adr=ptr; dat=popped word. All are held stable until lbram_wb_ack_i.
  - On ack: drop cyc/stb/we and return to IDLE.
  - ptr wrap rule on ack: if ptr==MEM_WORDS-1, then with wrap=1 ptr<=0; with wrap=0 ptr stays, full<=1 and the FIFO is flushed. Otherwise ptr<=ptr+1.
  - Consequence: minimum 3 cycles per word with single-cycle ack (pop, write, ack/IDLE).
- Latency: a sample accepted at edge N is in the FIFO after N. At the earliest, stb is asserted after edge N+1 (IDLE pop), and the ptr update happens at the ack edge.
- clear:
  - Sets clear_pend; it is applied only in IDLE, so a bus cycle is never aborted mid-transfer.
  - clear in the same cycle as sample_vld_i: clear wins, sample dropped.
- enable:
  - Gates acceptance only. Clearing enable does not stop the drain: queued samples are still written.
- full:
  - With full=1, writing 1 to enable does not restart logging; only clear resets full.
  - log_full_o = full.
- Reset mid-WRITE: cyc/stb drop immediately (async); the blockram must tolerate an aborted cycle.
- Simultaneous sbus CTRL write and ack-driven ptr update: both apply. The ptr update is independent of CTRL except for a pending clear.

Decomposition:
- Shared package logging_pkg:
  - register offsets REG_CTRL=0x0, REG_PTR=0x2
  - CTRL bit positions (EN, WRAP, CLR, FULL, OVF, BUSY)
  - FSM state typedef {IDLE, WRITE}
  - MEM_WORDS/ADR_W defaults, shared with the memory window
- One sub-module: logging_sample_fifo.
  - Synchronous FIFO, 16 x 2**FIFO_DEPTH_LOG2, with push/pop/flush/full/empty; flush has priority over push/pop.

Test Plan:
- Basic: enable=1, send 0x1111, 0x2222, 0x3333 with single-cycle ack → bram writes adr 0,1,2 with those data; PTR reads 3; busy returns to 0.
- Backpressure: ack delayed 5 cycles, 6 samples back-to-back → the first 5 are stored (1 in flight + 4 queued); the 6th is dropped with overflow=1; the bram sees ordered data and cyc/stb/adr/dat stable during the wait.
- Full stop: wrap=0, set ptr region full by logging 2048 samples → last write at adr 2047; full=1; log_full_o=1; the 2049th sample produces no bram cycle; PTR=2047.
- Wrap: wrap=1, 2050 samples → writes at 2047, 0, 1; full stays 0.
- Clear mid-write: write CTRL=0x5 while a stalled write is in WRITE → the cycle completes at the old adr, then ptr=0, flags 0, FIFO empty; a same-cycle sample_vld_i is dropped.
- Async reset asserted during WRITE → cyc/stb/we drop without waiting for a clock; all registers read 0.

Source files
------------

// File: rtl/logging_pkg.sv
// Shared definitions for the logging blockram producer and the sbus memory window.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package logging_pkg;

   // Blockram geometry, shared with the memory window.
   localparam int LOG_ADR_W           = 12;
   localparam int LOG_MEM_WORDS       = 2048;
   localparam int LOG_FIFO_DEPTH_LOG2 = 2;

   // sbus register offsets (only address bit 1 is decoded).
   localparam logic [15:0] REG_CTRL = 16'h0000;
   localparam logic [15:0] REG_PTR  = 16'h0002;

   // CTRL/STAT bit positions.
   localparam int CTRL_EN   = 0;
   localparam int CTRL_WRAP = 1;
   localparam int CTRL_CLR  = 2;
   localparam int CTRL_FULL = 8;
   localparam int CTRL_OVF  = 9;
   localparam int CTRL_BUSY = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } log_state_e;

endpackage

// File: rtl/logging_sample_fifo.sv
// Synchronous sample FIFO, 2**DEPTH_LOG2 words; flush has priority over push/pop.
// Latency: a pushed word is visible at head_dat_o after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller checks full_o/empty_o.
// Ports: wb_clk_i/wb_rst_i clock and async reset; push_i/push_dat_i write side;
//        pop_i/head_dat_o read side (head is combinational); flush_i empties; full_o/empty_o status.
module logging_sample_fifo #(
   parameter int W          = 16,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [W-1:0] head_dat_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [W-1:0]          mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full_o     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q.
   always_ff @(posedge wb_clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/logging_capture_writer.sv
// Buffers a 16-bit sample stream and writes it to the logging blockram at an auto-incrementing pointer.
// Latency: sample accepted at edge N -> stb high after N+1 -> ptr advances on the ack edge (>=3 cycles/word).
// Backpressure: none upstream; samples arriving with the 4-deep FIFO full are dropped and flagged as overflow.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; sample_dat_i/sample_vld_i sample strobe;
//        sbus_wb_* 2-register slave (CTRL/STAT at 0x0, PTR at 0x2); lbram_wb_* blockram write master;
//        log_full_o log-full flag.
module logging_capture_writer
   import logging_pkg::*;
#(
   parameter int ADR_W           = LOG_ADR_W,
   parameter int MEM_WORDS       = LOG_MEM_WORDS,
   parameter int FIFO_DEPTH_LOG2 = LOG_FIFO_DEPTH_LOG2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [15:0]      sample_dat_i,
   input  logic             sample_vld_i,
   input  logic             sbus_wb_cyc_i,
   input  logic             sbus_wb_stb_i,
   input  logic             sbus_wb_we_i,
   input  logic [15:0]      sbus_wb_adr_i,
   input  logic [1:0]       sbus_wb_sel_i,
   input  logic [15:0]      sbus_wb_dat_i,
   output logic [15:0]      sbus_wb_dat_o,
   output logic             sbus_wb_ack_o,
   output logic             lbram_wb_cyc_o,
   output logic             lbram_wb_stb_o,
   output logic             lbram_wb_we_o,
   output logic [ADR_W-1:0] lbram_wb_adr_o,
   output logic [15:0]      lbram_wb_dat_o,
   input  logic             lbram_wb_ack_i,
   output logic             log_full_o
);

   localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(MEM_WORDS - 1);

   log_state_e       state_q, state_d;
   logic [ADR_W-1:0] ptr_q, ptr_d;
   logic [15:0]      data_q, data_d;
   logic             enable_q, enable_d;
   logic             wrap_q, wrap_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             clr_pend_q, clr_pend_d;

   logic             reg_acc, sel_ctrl, sel_ptr, ctrl_wr, clr_wr, accept;
   logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [15:0]      fifo_head;
   logic [15:0]      ctrl_rd;
   logic             unused_ok;

   assign unused_ok = ^{sbus_wb_sel_i, sbus_wb_adr_i[15:2], sbus_wb_adr_i[0], sbus_wb_dat_i[15:3]};

   assign reg_acc  = sbus_wb_cyc_i && sbus_wb_stb_i;
   assign sel_ctrl = (sbus_wb_adr_i[1] == REG_CTRL[1]);
   assign sel_ptr  = (sbus_wb_adr_i[1] == REG_PTR[1]);
   assign ctrl_wr  = reg_acc && sbus_wb_we_i && sel_ctrl;
   assign clr_wr   = ctrl_wr && sbus_wb_dat_i[CTRL_CLR];

   // A clear being written this cycle already blocks acceptance, so clear wins over a same-cycle sample.
   assign accept    = sample_vld_i && enable_q && !full_q && !clr_pend_q && !clr_wr;
   assign fifo_push = accept && !fifo_full;

   logging_sample_fifo #(
      .W          (16),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .push_i     (fifo_push),
      .push_dat_i (sample_dat_i),
      .pop_i      (fifo_pop),
      .flush_i    (fifo_flush),
      .head_dat_o (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         data_q     <= '0;
         enable_q   <= 1'b0;
         wrap_q     <= 1'b0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         data_q     <= data_d;
         enable_q   <= enable_d;
         wrap_q     <= wrap_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         clr_pend_q <= clr_pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      data_d     = data_q;
      enable_d   = enable_q;
      wrap_d     = wrap_q;
      full_d     = full_q;
      ovf_d      = ovf_q;
      clr_pend_d = clr_pend_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;

      if (accept && fifo_full) ovf_d = 1'b1;

      case (state_q)
         IDLE: begin
            // A pending clear is only applied here so an in-flight bus cycle always completes.
            if (clr_pend_q) begin
               ptr_d      = '0;
               full_d     = 1'b0;
               ovf_d      = 1'b0;
               fifo_flush = 1'b1;
               clr_pend_d = 1'b0;
            end else if (!fifo_empty && !full_q) begin
               fifo_pop = 1'b1;
               data_d   = fifo_head;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            if (lbram_wb_ack_i) begin
               state_d = IDLE;
               if (ptr_q == LAST_ADR) begin
                  if (wrap_q) begin
                     ptr_d = '0;
                  end else begin
                     // Log is full: hold ptr at the last word and discard anything still queued.
                     full_d     = 1'b1;
                     fifo_flush = 1'b1;
                  end
               end else begin
                  ptr_d = ptr_q + ADR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (ctrl_wr) begin
         enable_d = sbus_wb_dat_i[CTRL_EN];
         wrap_d   = sbus_wb_dat_i[CTRL_WRAP];
         if (sbus_wb_dat_i[CTRL_CLR]) clr_pend_d = 1'b1;
      end
   end

   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd[CTRL_EN]   = enable_q;
      ctrl_rd[CTRL_WRAP] = wrap_q;
      ctrl_rd[CTRL_FULL] = full_q;
      ctrl_rd[CTRL_OVF]  = ovf_q;
      ctrl_rd[CTRL_BUSY] = (state_q != IDLE) || !fifo_empty;
   end

   assign sbus_wb_ack_o  = reg_acc;
   assign sbus_wb_dat_o  = sel_ptr ? {{(16-ADR_W){1'b0}}, ptr_q} : ctrl_rd;

   assign lbram_wb_cyc_o = (state_q == WRITE);
   assign lbram_wb_stb_o = (state_q == WRITE);
   assign lbram_wb_we_o  = (state_q == WRITE);
   assign lbram_wb_adr_o = ptr_q;
   assign lbram_wb_dat_o = data_q;
   assign log_full_o     = full_q;

endmodule
